// File: rtl/fir_interp_x4.sv
// fir_interp_x4: polyphase 1:4 interpolating FIR with one time-shared MAC.
// Each accepted 12-bit sample produces four filtered output samples, one per
// phase. Each phase output is sat12((sum_j h[4j+p]*x[j]) >>> 9), and the
// 8 products of a phase are accumulated over 8 cycles.
//
// Ports
//   Clk        clock, rising edge
//   Hlt_n      asynchronous active-low reset
//   Clr        synchronous clear: empty history, drop any pending output, go idle
//   In_data    input sample, two's complement
//   In_valid   input sample present
//   In_ready   combinational; high only when idle and Clr is low
//   Out_data   registered output sample, two's complement
//   Out_valid  Out_data valid, held until Out_ready
//   Out_ready  downstream accepts Out_data
module fir_interp_x4 #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned L      = 4,
    parameter int unsigned TAPS   = 32,
    parameter int unsigned ACC_W  = 28
) (
    input  logic              Clk,
    input  logic              Hlt_n,
    input  logic              Clr,
    input  logic [DATA_W-1:0] In_data,
    input  logic              In_valid,
    output logic              In_ready,
    output logic [DATA_W-1:0] Out_data,
    output logic              Out_valid,
    input  logic              Out_ready
);

    localparam int unsigned PH_TAPS = TAPS / L;
    localparam int unsigned PHASE_W = $clog2(L);
    localparam int unsigned TAP_W   = $clog2(PH_TAPS);
    localparam int unsigned PROD_W  = DATA_W + COEF_W;
    localparam int unsigned SHIFT   = 9;
    localparam int unsigned HEAD_W  = ACC_W - DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                     state, state_d;
    logic signed [DATA_W-1:0]   hist   [PH_TAPS];
    logic signed [DATA_W-1:0]   hist_d [PH_TAPS];
    logic signed [ACC_W-1:0]    acc, acc_d;
    logic [PHASE_W-1:0]         phase, phase_d;
    logic [TAP_W-1:0]           tap, tap_d;
    logic [DATA_W-1:0]          out_data_d;
    logic                       out_valid_d;

    logic signed [COEF_W-1:0]   coef;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    shifted;
    logic [DATA_W-1:0]          sat_val;

    // Symmetric 32-tap prototype: only h[0..15] is stored, h[31-k] = h[k].
    function automatic logic signed [COEF_W-1:0] coef_rom(input logic [4:0] idx);
        logic [3:0] k;
        k = idx[4] ? ~idx[3:0] : idx[3:0];
        case (k)
            4'd0:    coef_rom = COEF_W'(-3);
            4'd1:    coef_rom = COEF_W'(0);
            4'd2:    coef_rom = COEF_W'(1);
            4'd3:    coef_rom = COEF_W'(4);
            4'd4:    coef_rom = COEF_W'(10);
            4'd5:    coef_rom = COEF_W'(19);
            4'd6:    coef_rom = COEF_W'(31);
            4'd7:    coef_rom = COEF_W'(46);
            4'd8:    coef_rom = COEF_W'(64);
            4'd9:    coef_rom = COEF_W'(83);
            4'd10:   coef_rom = COEF_W'(103);
            4'd11:   coef_rom = COEF_W'(123);
            4'd12:   coef_rom = COEF_W'(141);
            4'd13:   coef_rom = COEF_W'(156);
            4'd14:   coef_rom = COEF_W'(167);
            default: coef_rom = COEF_W'(173);
        endcase
    endfunction

    assign In_ready = (state == ST_IDLE) && !Clr;

    // Datapath: coefficient h[tap*L + phase] times x[tap], running sum, scaling.
    always_comb begin
        coef    = coef_rom({tap, phase});
        prod    = PROD_W'(coef) * PROD_W'(hist[tap]);
        acc_sum = acc + ACC_W'(prod);
        shifted = acc_sum >>> SHIFT;
        // In range when every bit above the output sign bit matches it.
        if (shifted[ACC_W-1:DATA_W-1] == {HEAD_W{shifted[ACC_W-1]}}) begin
            sat_val = shifted[DATA_W-1:0];
        end else if (shifted[ACC_W-1]) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d     = state;
        hist_d      = hist;
        acc_d       = acc;
        phase_d     = phase;
        tap_d       = tap;
        out_data_d  = Out_data;
        out_valid_d = Out_valid;

        unique case (state)
            ST_IDLE: begin
                if (In_valid && In_ready) begin
                    for (int j = 1; j < PH_TAPS; j++) begin
                        hist_d[j] = hist[j-1];
                    end
                    hist_d[0] = In_data;
                    phase_d   = '0;
                    tap_d     = '0;
                    acc_d     = '0;
                    state_d   = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_sum;
                tap_d = tap + TAP_W'(1);
                if (tap == TAP_W'(PH_TAPS - 1)) begin
                    out_data_d  = sat_val;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (Out_ready) begin
                    out_valid_d = 1'b0;
                    if (phase != PHASE_W'(L - 1)) begin
                        phase_d = phase + PHASE_W'(1);
                        tap_d   = '0;
                        acc_d   = '0;
                        state_d = ST_MAC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear wins over everything, including a same-cycle handshake.
        if (Clr) begin
            for (int j = 0; j < PH_TAPS; j++) begin
                hist_d[j] = '0;
            end
            acc_d       = '0;
            phase_d     = '0;
            tap_d       = '0;
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Hlt_n) begin
        if (!Hlt_n) begin
            state <= ST_IDLE;
            for (int j = 0; j < PH_TAPS; j++) begin
                hist[j] <= '0;
            end
            acc       <= '0;
            phase     <= '0;
            tap       <= '0;
            Out_data  <= '0;
            Out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            hist      <= hist_d;
            acc       <= acc_d;
            phase     <= phase_d;
            tap       <= tap_d;
            Out_data  <= out_data_d;
            Out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fir_interp_x4.sv
// Scoreboard bench for fir_interp_x4: stimulus pushes expected outputs,
// a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_fir_interp_x4;

    localparam int unsigned DATA_W = 12;

    logic              Clk = 1'b0;
    logic              Hlt_n;
    logic              Clr;
    logic [DATA_W-1:0] In_data;
    logic              In_valid;
    logic              In_ready;
    logic [DATA_W-1:0] Out_data;
    logic              Out_valid;
    logic              Out_ready = 1'b1;

    fir_interp_x4 dut (
        .Clk       (Clk),
        .Hlt_n     (Hlt_n),
        .Clr       (Clr),
        .In_data   (In_data),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Out_data  (Out_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready)
    );

    always #5 Clk = ~Clk;

    int H [32] = '{-3, 0, 1, 4, 10, 19, 31, 46, 64, 83, 103, 123, 141, 156, 167, 173,
                   173, 167, 156, 141, 123, 103, 83, 64, 46, 31, 19, 10, 4, 1, 0, -3};

    int checks = 0;
    int errors = 0;
    int exp_q [$];
    int u [$];
    int hs_edge [$];
    int cyc = 0;
    int acc_edge = 0;
    int rdy_mode = 0;
    int stall_cnt = 0;
    bit stall_done = 1'b0;
    bit chk_stall = 1'b0;
    bit stall_prev = 1'b0;
    int prev_data = 0;
    int mon_s;
    int mon_e;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each accepted output against the scoreboard queue.
    always @(negedge Clk) begin
        if (Hlt_n && !Clr) begin
            mon_s = int'($signed(Out_data));
            if (chk_stall && stall_prev) begin
                check("stall_valid", int'(Out_valid), 1);
                check("stall_data", mon_s, prev_data);
            end
            if (Out_valid) check("in_ready_busy", int'(In_ready), 0);
            if (Out_valid && Out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got %0d expected no output at cycle %0d", mon_s, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", mon_s, mon_e);
                end
                hs_edge.push_back(cyc + 1);
            end
            stall_prev = Out_valid && !Out_ready;
            prev_data  = mon_s;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Out_ready driver: 0 = always ready, 1 = random with one 20-cycle stall, 2 = never ready.
    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0: Out_ready = 1'b1;
            1: begin
                if (stall_cnt > 0) begin
                    Out_ready = 1'b0;
                    stall_cnt--;
                end else if (!stall_done && Out_valid) begin
                    Out_ready  = 1'b0;
                    stall_cnt  = 19;
                    stall_done = 1'b1;
                end else begin
                    Out_ready = 1'($urandom_range(0, 1));
                end
            end
            default: Out_ready = 1'b0;
        endcase
    end

    // Present one sample until accepted; acc_edge is the accepting edge.
    task automatic accept(input int s);
        bit ok;
        ok = 1'b0;
        In_data  = DATA_W'(s);
        In_valid = 1'b1;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge Clk);
            if (In_ready) begin
                ok = 1'b1;
                acc_edge = cyc + 1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: In_ready stayed 0 for sample %0d", s);
        end else begin
            @(posedge Clk);
        end
        #1 In_valid = 1'b0;
    endtask

    // Reference: zero-stuffed x4 stream convolved with the full 32-tap h.
    task automatic model_push(input int s);
        int i, sum, m, y;
        u.push_back(s);
        i = u.size() - 1;
        for (int p = 0; p < 4; p++) begin
            sum = 0;
            for (int k = 0; k < 32; k++) begin
                m = 4 * i + p - k;
                if (m >= 0 && (m % 4) == 0) sum += H[k] * u[m / 4];
            end
            y = sum >>> 9;
            if (y > 2047) y = 2047;
            else if (y < -2048) y = -2048;
            exp_q.push_back(y);
        end
    endtask

    task automatic send(input int s);
        accept(s);
        model_push(s);
    endtask

    task automatic send_exp(input int s, input int e0, input int e1, input int e2, input int e3);
        accept(s);
        u.push_back(s);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
    endtask

    task automatic send_impulse();
        int n;
        for (int i = 0; i < 10; i++) begin
            accept(i == 0 ? 512 : 0);
            u.push_back(i == 0 ? 512 : 0);
            for (int p = 0; p < 4; p++) begin
                n = 4 * i + p;
                exp_q.push_back(n < 32 ? H[n] : 0);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge Clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs missing", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic clear_dut();
        @(posedge Clk);
        #1 Clr = 1'b1;
        @(posedge Clk);
        #1 Clr = 1'b0;
        exp_q.delete();
        u.delete();
    endtask

    int t0;
    bit seen;

    initial begin
        Hlt_n    = 1'b0;
        Clr      = 1'b0;
        In_valid = 1'b0;
        In_data  = '0;
        repeat (3) @(posedge Clk);
        #2 Hlt_n = 1'b1;
        @(negedge Clk);
        check("rst_out_valid", int'(Out_valid), 0);
        check("rst_out_data", int'(Out_data), 0);
        check("rst_in_ready", int'(In_ready), 1);
        @(posedge Clk);
        #1;

        // Impulse response equals the coefficient set, then zeros.
        send_impulse();
        drain();

        // DC 1000: transient from the model, steady state hand values.
        clear_dut();
        for (int i = 0; i < 12; i++) begin
            if (i < 7) send(1000);
            else send_exp(1000, 1089, 1093, 1093, 1089);
        end
        drain();

        // Saturation at both rails.
        clear_dut();
        for (int i = 0; i < 10; i++) begin
            if (i < 7) send(2047);
            else send_exp(2047, 2047, 2047, 2047, 2047);
        end
        drain();
        clear_dut();
        for (int i = 0; i < 10; i++) begin
            if (i < 7) send(-2048);
            else send_exp(-2048, -2048, -2048, -2048, -2048);
        end
        drain();

        // Backpressure: random ready with one long stall.
        clear_dut();
        stall_done = 1'b0;
        chk_stall  = 1'b1;
        rdy_mode   = 1;
        send_impulse();
        drain();
        chk_stall = 1'b0;
        rdy_mode  = 0;
        repeat (2) @(posedge Clk);
        #1;

        // Handshake timing for a single sample.
        clear_dut();
        hs_edge.delete();
        send(300);
        t0 = acc_edge;
        while (cyc < t0 + 36) begin
            @(negedge Clk);
            if (cyc == t0 + 35) check("in_ready_before_idle", int'(In_ready), 0);
            if (cyc == t0 + 36) check("in_ready_T37", int'(In_ready), 1);
        end
        drain();
        check("hs_count", hs_edge.size(), 4);
        for (int k = 0; k < 4 && k < hs_edge.size(); k++) begin
            check("hs_latency", hs_edge[k] - t0, 9 * (k + 1));
        end

        // Clr in the MAC of phase 2.
        clear_dut();
        accept(512);
        t0 = acc_edge;
        u.push_back(512);
        for (int p = 0; p < 4; p++) exp_q.push_back(H[p]);
        while (cyc < t0 + 20) @(negedge Clk);
        @(posedge Clk);
        #1 Clr = 1'b1;
        @(posedge Clk);
        #1 Clr = 1'b0;
        check("clr_q_pending", exp_q.size(), 2);
        exp_q.delete();
        u.delete();
        @(negedge Clk);
        check("clr_out_valid", int'(Out_valid), 0);
        check("clr_in_ready", int'(In_ready), 1);
        repeat (40) @(posedge Clk);
        #1;

        // Reset pulse while an output is pending.
        rdy_mode = 2;
        accept(512);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge Clk);
            if (Out_valid) seen = 1'b1;
        end
        check("hold_out_valid", int'(seen), 1);
        Hlt_n = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(Out_valid), 0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Hlt_n = 1'b1;
        rdy_mode = 0;
        exp_q.delete();
        u.delete();
        @(negedge Clk);
        check("rst_mid_in_ready", int'(In_ready), 1);
        check("rst_mid_out_data", int'(Out_data), 0);
        @(posedge Clk);
        #1;
        send_impulse();
        drain();
        repeat (20) @(posedge Clk);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
